// File: rtl/morse_decoder.sv
// Morse keyer decoder: classifies tap presses into dots/dashes, assembles letters,
// and emits ASCII characters, word spaces and a message-send strobe.
module morse_decoder #(
    parameter int DASH_CYCLES = 25_000_000,
    parameter int LETTER_GAP  = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic       cclk,
    input  logic       rstb,
    input  logic       tap,
    input  logic       space,
    input  logic       send,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       msg_send,
    output logic [2:0] pend_len
);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, FLUSH} state_t;

    localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP - 1);

    state_t           state, state_nxt;
    logic [4:0]       sym, sym_nxt;
    logic [2:0]       len, len_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] press_cnt, press_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_nxt;
    logic             space_q, send_q;
    logic             flush_send, flush_send_nxt;
    logic             cv_nxt, ms_nxt;
    logic [7:0]       cd_nxt;
    logic             space_rise, send_rise, btn_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    // Key is {len, sym}; the first element sent sits at bit len-1.
    function automatic logic [7:0] lookup(input logic [2:0] l, input logic [4:0] s,
                                          input logic o);
        logic [7:0] c;
        case ({l, s})
            8'b001_00000: c = 8'h45; // E
            8'b001_00001: c = 8'h54; // T
            8'b010_00000: c = 8'h49; // I
            8'b010_00001: c = 8'h41; // A
            8'b010_00010: c = 8'h4E; // N
            8'b010_00011: c = 8'h4D; // M
            8'b011_00000: c = 8'h53; // S
            8'b011_00001: c = 8'h55; // U
            8'b011_00010: c = 8'h52; // R
            8'b011_00011: c = 8'h57; // W
            8'b011_00100: c = 8'h44; // D
            8'b011_00101: c = 8'h4B; // K
            8'b011_00110: c = 8'h47; // G
            8'b011_00111: c = 8'h4F; // O
            8'b100_00000: c = 8'h48; // H
            8'b100_00001: c = 8'h56; // V
            8'b100_00010: c = 8'h46; // F
            8'b100_00100: c = 8'h4C; // L
            8'b100_00110: c = 8'h50; // P
            8'b100_00111: c = 8'h4A; // J
            8'b100_01000: c = 8'h42; // B
            8'b100_01001: c = 8'h58; // X
            8'b100_01010: c = 8'h43; // C
            8'b100_01011: c = 8'h59; // Y
            8'b100_01100: c = 8'h5A; // Z
            8'b100_01101: c = 8'h51; // Q
            8'b101_00000: c = 8'h35;
            8'b101_00001: c = 8'h34;
            8'b101_00011: c = 8'h33;
            8'b101_00111: c = 8'h32;
            8'b101_01111: c = 8'h31;
            8'b101_10000: c = 8'h36;
            8'b101_11000: c = 8'h37;
            8'b101_11100: c = 8'h38;
            8'b101_11110: c = 8'h39;
            8'b101_11111: c = 8'h30;
            default:      c = 8'h3F;
        endcase
        return o ? 8'h3F : c;
    endfunction

    assign space_rise = space & ~space_q;
    assign send_rise  = send & ~send_q;
    assign btn_rise   = space_rise | send_rise;
    assign pend_len   = len;

    always_comb begin
        state_nxt      = state;
        sym_nxt        = sym;
        len_nxt        = len;
        ovf_nxt        = ovf;
        press_nxt      = press_cnt;
        gap_nxt        = gap_cnt;
        flush_send_nxt = flush_send;
        cv_nxt         = 1'b0;
        ms_nxt         = 1'b0;
        cd_nxt         = char_data;
        case (state)
            IDLE, GAP: begin
                // Button edges win over a simultaneous tap rise or gap timeout.
                if (btn_rise) begin
                    if (len != 3'd0) begin
                        cv_nxt         = 1'b1;
                        cd_nxt         = lookup(len, sym, ovf);
                        flush_send_nxt = send_rise;
                        state_nxt      = FLUSH;
                    end else begin
                        if (send_rise) begin
                            ms_nxt = 1'b1;
                        end else begin
                            cv_nxt = 1'b1;
                            cd_nxt = 8'h20;
                        end
                        state_nxt = IDLE;
                    end
                    sym_nxt = 5'd0;
                    len_nxt = 3'd0;
                    ovf_nxt = 1'b0;
                end else if (tap) begin
                    press_nxt = CNT_W'(1);
                    state_nxt = PRESS;
                end else if (state == GAP) begin
                    if (gap_cnt >= GAP_LAST) begin
                        if (len != 3'd0) begin
                            cv_nxt = 1'b1;
                            cd_nxt = lookup(len, sym, ovf);
                        end
                        sym_nxt   = 5'd0;
                        len_nxt   = 3'd0;
                        ovf_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt = sat_inc(gap_cnt, GAP_LAST);
                    end
                end
            end
            PRESS: begin
                if (tap) begin
                    press_nxt = sat_inc(press_cnt, DASH_LIM);
                end else begin
                    if (len < 3'd5) begin
                        sym_nxt = {sym[3:0], (press_cnt >= DASH_LIM)};
                        len_nxt = len + 3'd1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                    gap_nxt   = '0;
                    state_nxt = GAP;
                end
            end
            FLUSH: begin
                if (flush_send) begin
                    ms_nxt = 1'b1;
                end else begin
                    cv_nxt = 1'b1;
                    cd_nxt = 8'h20;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            sym        <= 5'd0;
            len        <= 3'd0;
            ovf        <= 1'b0;
            press_cnt  <= '0;
            gap_cnt    <= '0;
            space_q    <= 1'b0;
            send_q     <= 1'b0;
            flush_send <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= 8'h00;
            msg_send   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sym        <= sym_nxt;
            len        <= len_nxt;
            ovf        <= ovf_nxt;
            press_cnt  <= press_nxt;
            gap_cnt    <= gap_nxt;
            space_q    <= space;
            send_q     <= send;
            flush_send <= flush_send_nxt;
            char_valid <= cv_nxt;
            char_data  <= cd_nxt;
            msg_send   <= ms_nxt;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: stimulus tasks drive taps/buttons while a string-level
// Morse model predicts every strobe and the edge it lands on.
module tb_morse_decoder;
    localparam int DASH = 8;
    localparam int GAPL = 16;

    logic       cclk  = 1'b0;
    logic       rstb  = 1'b0;
    logic       tap   = 1'b0;
    logic       space = 1'b0;
    logic       send  = 1'b0;
    logic       char_valid;
    logic [7:0] char_data;
    logic       msg_send;
    logic [2:0] pend_len;

    int    n_checks = 0;
    int    n_errors = 0;
    int    edge_no  = 0;
    int    both_cnt = 0;
    string act_s    = "";
    string exp_s    = "";
    string pending  = "";
    int    pend_n   = 0;
    int    low_cnt  = 0;

    string morse_tbl [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."};

    morse_decoder #(.DASH_CYCLES(DASH), .LETTER_GAP(GAPL), .CNT_W(32)) dut (
        .cclk(cclk), .rstb(rstb), .tap(tap), .space(space), .send(send),
        .char_valid(char_valid), .char_data(char_data), .msg_send(msg_send),
        .pend_len(pend_len));

    always #5 cclk = ~cclk;

    always @(posedge cclk) edge_no <= edge_no + 1;

    initial forever begin
        @(negedge cclk);
        if (char_valid && msg_send) both_cnt++;
        if (char_valid) act_s = {act_s, $sformatf("C%02h@%0d ", char_data, edge_no)};
        if (msg_send) act_s = {act_s, $sformatf("M@%0d ", edge_no)};
    end

    function automatic logic [7:0] ref_char(string code, int n);
        if (n > 5) return 8'h3F;
        for (int i = 0; i < 36; i++)
            if (morse_tbl[i] == code) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
        return 8'h3F;
    endfunction

    function automatic int exp_len();
        return (pend_n > 5) ? 5 : pend_n;
    endfunction

    task automatic step();
        @(posedge cclk);
        @(negedge cclk);
    endtask

    task automatic do_press(int n);
        tap = 1'b1;
        repeat (n) step();
        tap = 1'b0;
        pend_n++;
        if (pend_n <= 5) begin
            if (n >= DASH) pending = {pending, "-"};
            else pending = {pending, "."};
        end
        low_cnt = 0;
    endtask

    task automatic do_gap(int g);
        tap = 1'b0;
        repeat (g) begin
            step();
            if (pend_n > 0) begin
                low_cnt++;
                if (low_cnt == GAPL + 1) begin
                    exp_s = {exp_s, $sformatf("C%02h@%0d ", ref_char(pending, pend_n), edge_no)};
                    pending = "";
                    pend_n  = 0;
                end
            end
        end
    endtask

    task automatic do_button(bit sp, bit sd, int hold);
        space = sp;
        send  = sd;
        step();
        if (sp || sd) begin
            if (pend_n > 0) begin
                exp_s = {exp_s, $sformatf("C%02h@%0d ", ref_char(pending, pend_n), edge_no)};
                if (sd) exp_s = {exp_s, $sformatf("M@%0d ", edge_no + 1)};
                else exp_s = {exp_s, $sformatf("C20@%0d ", edge_no + 1)};
            end else begin
                if (sd) exp_s = {exp_s, $sformatf("M@%0d ", edge_no)};
                else exp_s = {exp_s, $sformatf("C20@%0d ", edge_no)};
            end
        end
        pending = "";
        pend_n  = 0;
        repeat (hold - 1) step();
        space = 1'b0;
        send  = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++; if (char_valid !== 1'b0) begin n_errors++; $display("FAIL rst_cv: got %b want 0", char_valid); end
        n_checks++; if (char_data !== 8'h00) begin n_errors++; $display("FAIL rst_cd: got %h want 00", char_data); end
        n_checks++; if (msg_send !== 1'b0) begin n_errors++; $display("FAIL rst_ms: got %b want 0", msg_send); end
        n_checks++; if (pend_len !== 3'd0) begin n_errors++; $display("FAIL rst_len: got %0d want 0", pend_len); end
        rstb = 1'b1;
        step();
        act_s = ""; exp_s = "";
        do_button(1'b1, 1'b0, 1);
        do_press(3);
        do_gap(1);
        n_checks++; if (pend_len !== 3'd1) begin n_errors++; $display("FAIL rst_pre_len: got %0d want 1", pend_len); end
        tap = 1'b1;
        repeat (3) step();
        #2 rstb = 1'b0;
        #1;
        n_checks++; if (char_data !== 8'h00) begin n_errors++; $display("FAIL async_cd: got %h want 00", char_data); end
        n_checks++; if (pend_len !== 3'd0) begin n_errors++; $display("FAIL async_len: got %0d want 0", pend_len); end
        n_checks++; if ({char_valid, msg_send} !== 2'b00) begin n_errors++; $display("FAIL async_strobes: got %b want 00", {char_valid, msg_send}); end
        pending = ""; pend_n = 0; low_cnt = 0;
        repeat (3) step();
        tap = 1'b0;
        step();
        rstb = 1'b1;
        repeat (GAPL * 3) step();
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL rst_events: got '%s' want '%s'", act_s, exp_s); end
        n_checks++; if (pend_len !== 3'd0) begin n_errors++; $display("FAIL rst_post_len: got %0d want 0", pend_len); end
    endtask

    task automatic test_letter_a();
        act_s = ""; exp_s = "";
        do_press(3);
        do_gap(1);
        n_checks++; if (pend_len !== 3'(exp_len())) begin n_errors++; $display("FAIL a_len1: got %0d want %0d", pend_len, exp_len()); end
        do_gap(1);
        do_press(10);
        do_gap(1);
        n_checks++; if (pend_len !== 3'(exp_len())) begin n_errors++; $display("FAIL a_len2: got %0d want %0d", pend_len, exp_len()); end
        do_gap(GAPL + 2);
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL a_events: got '%s' want '%s'", act_s, exp_s); end
        n_checks++; if (pend_len !== 3'd0) begin n_errors++; $display("FAIL a_len0: got %0d want 0", pend_len); end
    endtask

    task automatic test_boundary();
        act_s = ""; exp_s = "";
        do_press(DASH - 1);
        do_gap(GAPL + 2);
        do_press(DASH);
        do_gap(GAPL + 2);
        for (int grp = 0; grp < 3; grp++) begin
            for (int k = 0; k < 3; k++) begin
                do_press((grp == 1) ? DASH + 1 : 2);
                do_gap((k == 2) ? GAPL + 2 : 2);
            end
        end
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL boundary_events: got '%s' want '%s'", act_s, exp_s); end
    endtask

    task automatic test_space();
        act_s = ""; exp_s = "";
        for (int k = 0; k < 5; k++) begin
            do_press(DASH + 1);
            do_gap((k == 4) ? 1 : 2);
        end
        n_checks++; if (pend_len !== 3'd5) begin n_errors++; $display("FAIL space_len: got %0d want 5", pend_len); end
        do_button(1'b1, 1'b0, 1);
        repeat (3) step();
        do_button(1'b1, 1'b0, 1);
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL space_events: got '%s' want '%s'", act_s, exp_s); end
    endtask

    task automatic test_unknown_overflow();
        act_s = ""; exp_s = "";
        do_press(2); do_gap(2);
        do_press(2); do_gap(2);
        do_press(DASH); do_gap(2);
        do_press(DASH); do_gap(GAPL + 2);
        for (int k = 0; k < 6; k++) begin
            do_press(1);
            do_gap(1);
            n_checks++; if (pend_len !== 3'(exp_len())) begin n_errors++; $display("FAIL ovf_len%0d: got %0d want %0d", k, pend_len, exp_len()); end
        end
        do_gap(GAPL + 2);
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL ovf_events: got '%s' want '%s'", act_s, exp_s); end
    endtask

    task automatic test_send();
        act_s = ""; exp_s = "";
        do_press(3);
        do_gap(1);
        do_button(1'b0, 1'b1, 1);
        repeat (3) step();
        do_button(1'b0, 1'b1, 100);
        repeat (3) step();
        do_button(1'b1, 1'b1, 1);
        repeat (3) step();
        #1;
        n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL send_events: got '%s' want '%s'", act_s, exp_s); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            string code;
            int    mode;
            act_s = ""; exp_s = "";
            if ($urandom_range(0, 3) == 0) begin
                code = "";
                for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                    code = {code, ($urandom_range(0, 1) == 1) ? "-" : "."};
            end else begin
                code = morse_tbl[$urandom_range(0, 35)];
            end
            for (int k = 0; k < code.len(); k++) begin
                if (code[k] == "-") do_press(int'($urandom_range(DASH, DASH + 4)));
                else do_press(int'($urandom_range(1, DASH - 1)));
                if (k != code.len() - 1) do_gap(int'($urandom_range(1, GAPL - 1)));
            end
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                do_gap(int'($urandom_range(GAPL + 1, GAPL + 6)));
            end else begin
                do_gap(int'($urandom_range(1, GAPL)));
                do_button(mode == 1, mode == 2, int'($urandom_range(1, 4)));
            end
            do_gap(2);
            #1;
            n_checks++; if (act_s != exp_s) begin n_errors++; $display("FAIL rand%0d: got '%s' want '%s'", it, act_s, exp_s); end
            n_checks++; if (pend_len !== 3'd0) begin n_errors++; $display("FAIL rand%0d_len: got %0d want 0", it, pend_len); end
        end
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_cnt !== 0) begin n_errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_boundary();
        test_space();
        test_unknown_overflow();
        test_send();
        test_random();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Consumes the touch-decoded `tap`, `space` and `send` levels and turns them into Morse elements, ASCII characters and a message-send strobe. It sits downstream of the touchscreen front end and upstream of the message buffer and transmit logic. Dot or dash is chosen by how long `tap` is held. A letter is committed by a silent gap or by a `space`/`send` press.

## Interface
- `DASH_CYCLES`, 25_000_000: a `tap` high for at least this many cycles is a dash; shorter is a dot.
- `LETTER_GAP`, 50_000_000: consecutive `tap`-low cycles that commit the pending letter.
- `CNT_W`, 32: width of the press and gap counters. Must hold `max(DASH_CYCLES, LETTER_GAP)`.
- `cclk`  in  1  system clock.
- `rstb`  in  1  reset, asynchronous, active-low.
- `tap`  in  1  level, high while the tap region is held.
- `space`  in  1  level, high while the space region is held.
- `send`  in  1  level, high while the send region is held.
- `char_valid`  out  1  one-cycle strobe, `char_data` is valid.
- `char_data`  out  8  ASCII character.
- `msg_send`  out  1  one-cycle strobe, the message is complete.
- `pend_len`  out  3  number of elements pending in the current letter (0–5).

## Operation
- Registers:
  - `sym[4:0]`: element shift register, new element enters at the LSB, dash=1, dot=0.
  - `len[2:0]`: element count.
  - `ovf`: overflow flag.
  - `press_cnt`, `gap_cnt`.
  - `space_q`, `send_q`: edge-detect flops.
- States:
  - IDLE: no press in progress; a `tap` high moves to PRESS with `press_cnt`=1.
  - PRESS: `press_cnt` increments and saturates at `DASH_CYCLES`.
    - On the first cycle `tap` is sampled low, classify the element (dash if `press_cnt`≥`DASH_CYCLES`).
    - If `len`<5: `sym<={sym[3:0],e}`, `len++`. Otherwise set `ovf` and drop the element.
    - Go to GAP with `gap_cnt`=0.
  - GAP: `gap_cnt` increments each cycle `tap` is low.
    - `tap` high → PRESS, `press_cnt`=1.
    - `gap_cnt` reaches `LETTER_GAP`-1 → emit the letter, clear `sym`/`len`/`ovf`, go to IDLE.
  - FLUSH: one cycle, emits the queued space character or `msg_send`, then goes to IDLE.
- `space` rising edge (`space & ~space_q`), in IDLE or GAP:
  - If `len`>0: emit the letter this edge, queue a space, go to FLUSH.
  - Otherwise emit `char_data`=0x20 directly.
- `send` rising edge: same as `space`, except the queued or direct action is a `msg_send` pulse and no character.
- Priority:
  - `send` beats `space` when both edges occur in one cycle; the `space` edge is dropped.
  - `space`/`send` edges seen in PRESS are ignored.
  - A `tap` rise coincident with a `space`/`send` edge is ignored in favour of that edge.
- Lookup on `{len, sym}`:
  - A–Z map to 0x41–0x5A, 0–9 map to 0x30–0x39. Standard ITU codes, first element is the MSB of the used bits.
  - Any other code, or `ovf`=1, gives 0x3F ('?').
- `len`=0 with a gap timeout emits nothing.

## Timing
- Reset values: `char_valid`=0, `char_data`=0x00, `msg_send`=0, `pend_len`=0, state IDLE, all counters and flags 0.
- Reset is asynchronous. Asserting it mid-press or mid-gap discards the pending letter, and no strobe follows release.
- All outputs are registered. `char_valid` and `msg_send` are high for exactly one cycle and are never high together.
- `char_data` holds its last value between strobes.
- The element is appended at the edge where `tap` is first sampled low. `pend_len` updates at that same edge.
- Gap commit: `char_valid` rises at the `LETTER_GAP`-th edge after the edge that entered GAP, provided `tap` stayed low throughout.
- Press classification: exactly `DASH_CYCLES` sampled-high cycles is a dash; `DASH_CYCLES`-1 is a dot.
- Space or send with a pending letter: letter strobe at edge N, then space strobe or `msg_send` at edge N+1. No pending letter: single strobe at edge N.
- `space`/`send` held high produce a single event. A new event needs a low sample first.
- Counters saturate and never wrap.

## Test plan
Bench uses `DASH_CYCLES`=8, `LETTER_GAP`=16.
- Reset: `rstb` low asynchronously mid-cycle → all outputs 0 immediately. Hold `tap` high during reset, release → no strobe.
- Tap 3, gap 2, tap 10, gap 16 cycles → one `char_valid` with 0x41 ('A') at gap edge 16, `pend_len` 1→2→0.
- Boundary and sequence:
  - A 7-cycle press is a dot; an 8-cycle press is a dash.
  - Dot,dot,dot / dash,dash,dash / dot,dot,dot, each group followed by a 16-cycle gap → strobes 0x53, 0x4F, 0x53.
- Dash×5, then a `space` rise → 0x30 at edge N, 0x20 at edge N+1. A `space` rise with `len`=0 → single 0x20.
- Unknown and overflow: dot,dot,dash,dash then gap → 0x3F. Six dots then gap → 0x3F, `pend_len` saturates at 5.
- Dot then a `send` rise → 0x45 at edge N, `msg_send` at N+1. `send` held 100 cycles → one `msg_send` only. `space` and `send` rising together with `len`=0 → `msg_send` only.
